// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite bus types and the read-slave FSM state encoding.
// Imported by the read slave, its interface and the burst address helper.
package ahb3lite_pkg;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } HBURST_Type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } HTRANS_state;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } HRESP_state;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT,
    RD_DONE,
    RD_ERR1,
    RD_ERR2
  } rd_state_t;

endpackage

// File: rtl/cpu_dma_read_slave_if.sv
// CPU/DMA AHB-Lite read-side bus plus the local memory read port.
// The slave modport is the read slave; master is the bus/memory side.
interface cpu_dma_read_slave_if
  import ahb3lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  HBURST_Type            HBURST;
  logic [2:0]            HSIZE;
  HTRANS_state           HTRANS;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  HRESP_state            HRESP;
  logic [ADDR_WIDTH-1:0] mem_RD_addr;
  logic                  mem_read_flag;
  logic [DATA_WIDTH-1:0] mem_RD_data;
  logic                  mem_RD_valid;

  modport slave (
    input  HADDR, HWRITE, HBURST, HSIZE, HTRANS,
    input  mem_RD_data, mem_RD_valid,
    output HRDATA, HREADY, HRESP,
    output mem_RD_addr, mem_read_flag
  );

  modport master (
    output HADDR, HWRITE, HBURST, HSIZE, HTRANS,
    output mem_RD_data, mem_RD_valid,
    input  HRDATA, HREADY, HRESP,
    input  mem_RD_addr, mem_read_flag
  );
endinterface

// File: rtl/ahb3lite_burst_addr.sv
// Expected address of the next SEQ beat given the previous beat.
// Wrapping bursts stay inside a beats*size aligned block.
module ahb3lite_burst_addr
  import ahb3lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] prev_addr,
  input  logic [2:0]            size,
  input  HBURST_Type            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] inc;
  logic                  wrap;

  always_comb begin
    step = ADDR_WIDTH'(1) << size;
    wrap = 1'b1;
    span = step;
    unique case (burst)
      WRAP4:   span = step << 2;
      WRAP8:   span = step << 3;
      WRAP16:  span = step << 4;
      default: wrap = 1'b0;
    endcase
    mask = span - ADDR_WIDTH'(1);
    inc  = prev_addr + step;
    next_addr = wrap ? ((prev_addr & ~mask) | (inc & mask)) : inc;
  end
endmodule

// File: rtl/cpu_dma_read_slave.sv
// AHB-Lite read slave: bus reads -> local memory request/valid port.
// Optional READ_TIMEOUT_EN turns a stuck memory wait into an ERROR.
module cpu_dma_read_slave
  import ahb3lite_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0000_1000
`ifdef READ_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 16
`endif
) (
  input logic                 HCLK,
  input logic                 HRESET,
  cpu_dma_read_slave_if.slave bus
);
  localparam int LANE = $clog2(DATA_WIDTH / 8);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  rd_state_t             state;
  rd_state_t             state_nx;
  addr_t                 rd_addr;
  logic [DATA_WIDTH-1:0] rdata;
  addr_t                 prev_addr;
  logic [2:0]            prev_size;
  HBURST_Type            prev_burst;
  logic                  hist_vld;
  addr_t                 next_addr;

  logic       ready;
  logic       flag;
  HRESP_state resp;
  logic       accept;
  logic       err;
  logic       bad_range;
  logic       bad_size;
  logic       bad_align;
  logic       bad_seq;
  addr_t      align_mask;
  logic [ADDR_WIDTH:0] diff;

  ahb3lite_burst_addr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_burst (
    .prev_addr(prev_addr),
    .size     (prev_size),
    .burst    (prev_burst),
    .next_addr(next_addr)
  );

  always_comb begin
    ready = 1'b1;
    resp  = OKAY;
    flag  = 1'b0;
    unique case (state)
      RD_REQ: begin
        ready = 1'b0;
        flag  = 1'b1;
      end
      RD_WAIT: ready = 1'b0;
      RD_ERR1: begin
        ready = 1'b0;
        resp  = ERROR;
      end
      RD_ERR2: resp = ERROR;
      default: ;
    endcase
  end

  // Extra MSB keeps the window check exact below MEM_BASE.
  always_comb begin
    accept = ready && !bus.HWRITE &&
             (bus.HTRANS == NONSEQ || bus.HTRANS == SEQ);
    diff = {1'b0, bus.HADDR} - {1'b0, addr_t'(MEM_BASE)};
    bad_range = diff[ADDR_WIDTH] ||
                (diff[ADDR_WIDTH-1:0] >= addr_t'(MEM_SIZE));
    bad_size = bus.HSIZE > 3'(LANE);
    align_mask = (addr_t'(1) << bus.HSIZE) - addr_t'(1);
    bad_align = |(bus.HADDR & align_mask);
    bad_seq = (bus.HTRANS == SEQ) &&
              (!hist_vld || prev_burst == SINGLE ||
               bus.HADDR != next_addr ||
               bus.HSIZE != prev_size);
    err = bad_range | bad_size | bad_align | bad_seq;
  end

`ifdef READ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      tmo_cnt <= '0;
    end else if (state == RD_WAIT) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      RD_IDLE, RD_DONE, RD_ERR2: begin
        if (accept) state_nx = err ? RD_ERR1 : RD_REQ;
        else        state_nx = RD_IDLE;
      end
      RD_REQ:  state_nx = RD_WAIT;
      RD_WAIT: begin
        if (bus.mem_RD_valid) state_nx = RD_DONE;
        else if (tmo_hit)     state_nx = RD_ERR1;
      end
      RD_ERR1: state_nx = RD_ERR2;
      default: state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= RD_IDLE;
      rd_addr    <= '0;
      rdata      <= '0;
      hist_vld   <= 1'b0;
      prev_addr  <= '0;
      prev_size  <= '0;
      prev_burst <= SINGLE;
    end else begin
      state <= state_nx;
      // A rejected beat breaks the burst, so any SEQ after it errors.
      if (accept) begin
        hist_vld <= !err;
        if (!err) begin
          prev_addr  <= bus.HADDR;
          prev_size  <= bus.HSIZE;
          prev_burst <= bus.HBURST;
          rd_addr    <= {bus.HADDR[ADDR_WIDTH-1:LANE], {LANE{1'b0}}};
        end
      end
      if (state == RD_WAIT && bus.mem_RD_valid) begin
        rdata <= bus.mem_RD_data;
      end
    end
  end

  assign bus.HRDATA        = rdata;
  assign bus.HREADY        = ready;
  assign bus.HRESP         = resp;
  assign bus.mem_RD_addr   = rd_addr;
  assign bus.mem_read_flag = flag;
endmodule

// File: tb/tb_cpu_dma_read_slave.sv
// Bench for cpu_dma_read_slave: directed + random reads vs a transfer model.
// Works with or without READ_TIMEOUT_EN defined.
module tb_cpu_dma_read_slave;
  import ahb3lite_pkg::*;

  localparam longint BASE = 64'h0;
  localparam longint SIZE = 64'h1000;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  cpu_dma_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cpu_dma_read_slave dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] last_data;

  bit          h_ok;
  logic [31:0] h_addr;
  int          h_size;
  HBURST_Type  h_burst;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] a, input int sz,
                                      input HBURST_Type b);
    longint ua, bytes, beats, span, base;
    ua = a;
    bytes = longint'(1) << sz;
    case (b)
      WRAP4:   beats = 4;
      WRAP8:   beats = 8;
      WRAP16:  beats = 16;
      default: beats = 0;
    endcase
    if (beats == 0) return 32'(ua + bytes);
    span = beats * bytes;
    base = ua - (ua % span);
    return 32'(base + ((ua - base + bytes) % span));
  endfunction

  task automatic model_step(input logic [31:0] a, input int sz,
                            input HBURST_Type b, input HTRANS_state t,
                            output bit e);
    longint ua;
    ua = a;
    e = (ua < BASE) || (ua >= BASE + SIZE);
    if (sz > 2) e = 1'b1;
    else if (ua % (longint'(1) << sz) != 0) e = 1'b1;
    if (t == SEQ) begin
      if (!h_ok || h_burst == SINGLE || sz != h_size ||
          a != nxt(h_addr, h_size, h_burst)) e = 1'b1;
    end
    h_ok = !e;
    if (!e) begin
      h_addr = a;
      h_size = sz;
      h_burst = b;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int sz,
                         input HBURST_Type b, input HTRANS_state t,
                         input int dly);
    bit e;
    logic [31:0] exp;
    model_step(a, sz, b, t, e);
    bus.HADDR = a;
    bus.HSIZE = 3'(sz);
    bus.HBURST = b;
    bus.HTRANS = t;
    bus.HWRITE = 1'b0;
    tick();
    bus.HTRANS = IDLE;
    bus.HADDR = $urandom;
    if (e) begin
      chk("err1_ready", 32'(bus.HREADY), 32'(0));
      chk("err1_resp", 32'(bus.HRESP), 32'(ERROR));
      chk("err1_flag", 32'(bus.mem_read_flag), 32'(0));
      tick();
      chk("err2_ready", 32'(bus.HREADY), 32'(1));
      chk("err2_resp", 32'(bus.HRESP), 32'(ERROR));
      chk("err2_flag", 32'(bus.mem_read_flag), 32'(0));
    end else begin
      exp = mem[a[11:2]];
      chk("req_flag", 32'(bus.mem_read_flag), 32'(1));
      chk("req_ready", 32'(bus.HREADY), 32'(0));
      chk("req_addr", bus.mem_RD_addr, {a[31:2], 2'b00});
      bus.mem_RD_valid = 1'b1;
      bus.mem_RD_data = ~exp;
      for (int i = 0; i <= dly; i++) begin
        tick();
        chk("wait_ready", 32'(bus.HREADY), 32'(0));
        chk("wait_flag", 32'(bus.mem_read_flag), 32'(0));
        bus.mem_RD_valid = (i == dly);
        bus.mem_RD_data = (i == dly) ? exp : $urandom;
      end
      tick();
      bus.mem_RD_valid = 1'b0;
      chk("done_ready", 32'(bus.HREADY), 32'(1));
      chk("done_resp", 32'(bus.HRESP), 32'(OKAY));
      chk("done_data", bus.HRDATA, exp);
      last_data = exp;
    end
  endtask

  task automatic idle_cycle(input HTRANS_state t, input logic w);
    bus.HTRANS = t;
    bus.HWRITE = w;
    bus.HADDR = 32'h40;
    bus.HSIZE = 3'd2;
    tick();
    bus.HTRANS = IDLE;
    bus.HWRITE = 1'b0;
    chk("idle_ready", 32'(bus.HREADY), 32'(1));
    chk("idle_resp", 32'(bus.HRESP), 32'(OKAY));
    chk("idle_flag", 32'(bus.mem_read_flag), 32'(0));
  endtask

  task automatic start_req(input logic [31:0] a);
    bit e;
    model_step(a, 2, SINGLE, NONSEQ, e);
    bus.HADDR = a;
    bus.HSIZE = 3'd2;
    bus.HBURST = SINGLE;
    bus.HTRANS = NONSEQ;
    tick();
    bus.HTRANS = IDLE;
    chk("stall_req_flag", 32'(bus.mem_read_flag), 32'(1));
  endtask

  HBURST_Type  rb;
  int          rsz;
  int          rbeats;
  logic [31:0] ra;
  logic [31:0] baddr;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;
    h_ok = 1'b0;
    h_addr = '0;
    h_size = 0;
    h_burst = SINGLE;
    last_data = '0;
    bus.HADDR = '0;
    bus.HWRITE = 1'b0;
    bus.HBURST = SINGLE;
    bus.HSIZE = 3'd2;
    bus.HTRANS = IDLE;
    bus.mem_RD_data = '0;
    bus.mem_RD_valid = 1'b0;

    #1;
    chk("rst_ready", 32'(bus.HREADY), 32'(1));
    chk("rst_resp", 32'(bus.HRESP), 32'(OKAY));
    chk("rst_data", bus.HRDATA, 32'h0);
    chk("rst_flag", 32'(bus.mem_read_flag), 32'(0));
    chk("rst_addr", bus.mem_RD_addr, 32'h0);
    tick();
    tick();
    HRESET = 1'b0;
    tick();

    do_read(32'h10, 2, SINGLE, NONSEQ, 0);
    chk("deadbeef", bus.HRDATA, 32'hDEAD_BEEF);

    do_read(32'h20, 2, INCR4, NONSEQ, 1);
    do_read(32'h24, 2, INCR4, SEQ, 0);
    do_read(32'h28, 2, INCR4, SEQ, 2);
    do_read(32'h2C, 2, INCR4, SEQ, 0);

    do_read(32'h38, 2, WRAP4, NONSEQ, 0);
    do_read(32'h3C, 2, WRAP4, SEQ, 1);
    do_read(32'h30, 2, WRAP4, SEQ, 0);
    do_read(32'h34, 2, WRAP4, SEQ, 3);
    idle_cycle(IDLE, 1'b0);
    do_read(32'h38, 2, WRAP4, NONSEQ, 0);
    do_read(32'h3C, 2, WRAP4, SEQ, 0);
    do_read(32'h40, 2, WRAP4, SEQ, 0);

    do_read(32'h1000, 2, SINGLE, NONSEQ, 0);
    do_read(32'h3, 1, SINGLE, NONSEQ, 0);
    do_read(32'h0, 3, SINGLE, NONSEQ, 0);
    do_read(32'h52, 1, SINGLE, NONSEQ, 1);
    do_read(32'h54, 1, SINGLE, SEQ, 0);
    do_read(32'h61, 0, WRAP8, NONSEQ, 0);
    do_read(32'h62, 0, WRAP8, SEQ, 1);
    do_read(32'hFFC, 2, INCR, NONSEQ, 0);
    do_read(32'h1000, 2, INCR, SEQ, 0);

    idle_cycle(IDLE, 1'b0);
    idle_cycle(BUSY, 1'b0);
    idle_cycle(NONSEQ, 1'b1);
    idle_cycle(SEQ, 1'b1);

    for (int n = 0; n < 30; n++) begin
      rb = HBURST_Type'($urandom_range(0, 7));
      rsz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      ra = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 64)
                                       : $urandom_range(0, 32'hFFF);
      if ($urandom_range(0, 7) != 0 && rsz < 3)
        ra = ra & ~((32'h1 << rsz) - 32'h1);
      rbeats = (rb == SINGLE) ? 1 : $urandom_range(1, 5);
      for (int k = 0; k < rbeats; k++) begin
        if (k == 0 || !h_ok) baddr = ra;
        else baddr = nxt(h_addr, h_size, h_burst);
        if (k != 0 && $urandom_range(0, 7) == 0) baddr = baddr + 32'h4;
        do_read(baddr, rsz, rb, (k == 0) ? NONSEQ : SEQ,
                $urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) idle_cycle(BUSY, 1'b0);
    end

`ifdef READ_TIMEOUT_EN
    start_req(32'h80);
    bus.mem_RD_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("tmo_wait_ready", 32'(bus.HREADY), 32'(0));
      chk("tmo_wait_resp", 32'(bus.HRESP), 32'(OKAY));
    end
    tick();
    chk("tmo_err1_ready", 32'(bus.HREADY), 32'(0));
    chk("tmo_err1_resp", 32'(bus.HRESP), 32'(ERROR));
    chk("tmo_err1_data", bus.HRDATA, last_data);
    bus.mem_RD_valid = 1'b1;
    bus.mem_RD_data = ~last_data;
    tick();
    bus.mem_RD_valid = 1'b0;
    chk("tmo_err2_ready", 32'(bus.HREADY), 32'(1));
    chk("tmo_err2_resp", 32'(bus.HRESP), 32'(ERROR));
    chk("tmo_late_data", bus.HRDATA, last_data);
    start_req(32'h84);
    tick();
`else
    start_req(32'h80);
    bus.mem_RD_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("stall_ready", 32'(bus.HREADY), 32'(0));
    end
`endif

    chk("pre_rst_data", 32'(bus.HRDATA != 32'h0), 32'(last_data != 32'h0));
    HRESET = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.HREADY), 32'(1));
    chk("arst_resp", 32'(bus.HRESP), 32'(OKAY));
    chk("arst_data", bus.HRDATA, 32'h0);
    chk("arst_flag", 32'(bus.mem_read_flag), 32'(0));
    chk("arst_addr", bus.mem_RD_addr, 32'h0);
    h_ok = 1'b0;
    tick();
    HRESET = 1'b0;
    bus.mem_RD_valid = 1'b1;
    bus.mem_RD_data = 32'hA5A5_5A5A;
    tick();
    bus.mem_RD_valid = 1'b0;
    chk("post_rst_data", bus.HRDATA, 32'h0);
    chk("post_rst_ready", 32'(bus.HREADY), 32'(1));

    do_read(32'h4, 2, INCR, SEQ, 0);
    do_read(32'h8, 2, SINGLE, NONSEQ, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_dma_read_slave.md
# cpu_dma_read_slave

AHB-Lite read-side slave for the CPU/DMA bus: accepts read transfers (HWRITE=0) from the CPU_DMA master, fetches words from the local memory over a request/valid read port, and returns them on HRDATA with wait states. It is the read counterpart of the existing write slave and shares the address/control bus with it. Out-of-range, misaligned, oversize or burst-inconsistent reads receive a two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 32, HADDR and mem_RD_addr width
- DATA_WIDTH, 32, HRDATA and mem_RD_data width; HSIZE up to log2(DATA_WIDTH/8)
- MEM_BASE, 32'h0000_0000, first byte address decoded
- MEM_SIZE, 32'h0000_1000, decoded window in bytes
- TIMEOUT_CYCLES, 16, memory wait limit (READ_TIMEOUT_EN only)

- HCLK  in  1  bus clock, all logic rising-edge
- HRESET  in  1  asynchronous, active-high reset
- HADDR  in  ADDR_WIDTH  address-phase address
- HWRITE  in  1  1=write (ignored by this block)
- HBURST  in  HBURST_Type  burst type
- HSIZE  in  3  transfer size
- HTRANS  in  HTRANS_state  IDLE/BUSY/NONSEQ/SEQ
- HRDATA  out  DATA_WIDTH  read data, registered
- HREADY  out  1  transfer done / ready for next address phase
- HRESP  out  HRESP_state  OKAY/ERROR
- mem_RD_addr  out  ADDR_WIDTH  word-aligned byte address
- mem_read_flag  out  1  one-cycle read request
- mem_RD_data  in  DATA_WIDTH  memory read data
- mem_RD_valid  in  1  mem_RD_data valid this cycle

## Operation
- Accept: rising edge with HREADY=1, HTRANS in {NONSEQ,SEQ}, HWRITE=0. Capture HADDR/HSIZE/HBURST.
- HTRANS IDLE/BUSY, or HWRITE=1: no access; HREADY stays 1, HRESP OKAY.
- Error checks at accept (any -> ERR1): HADDR outside [MEM_BASE, MEM_BASE+MEM_SIZE); HSIZE>2; HADDR not aligned to 1<<HSIZE; SEQ with HADDR != expected next burst address or HSIZE differing from previous beat.
- Expected next address: INCR/INCR4/8/16 = prev+(1<<HSIZE); WRAP4/8/16 wraps inside a beats*(1<<HSIZE) aligned block; SINGLE followed by SEQ is an error.
- States: IDLE -> REQ (valid read accepted) or ERR1 (error). REQ: mem_read_flag=1 one cycle, HREADY=0 -> WAIT. WAIT: HREADY=0 until mem_RD_valid; on valid register mem_RD_data into HRDATA -> DONE. DONE: HREADY=1, HRESP OKAY; new accept here goes to REQ/ERR1, else IDLE. ERR1: HREADY=0, HRESP ERROR -> ERR2. ERR2: HREADY=1, HRESP ERROR; transfer accepted here is processed normally.
- Full word returned for byte/half reads; master selects lane.
- mem_RD_valid outside WAIT ignored.

## Timing
- Reset: HRDATA=0, HREADY=1, HRESP=OKAY, mem_read_flag=0, mem_RD_addr=0, state IDLE, burst history cleared.
- Reset mid-transfer: outputs return to reset values asynchronously; later mem_RD_valid ignored.
- Accept at edge N: mem_read_flag high in cycle N+1; mem_RD_valid sampled from N+2; valid in cycle k -> HRDATA/HREADY=1 in k+1. Minimum 2 wait states.
- Back-to-back: DONE cycle is the next address phase; no idle cycle required between beats.
- ERROR: exactly ERR1 then ERR2; no memory request issued.

## Configuration
- READ_TIMEOUT_EN defined: counter starts in WAIT; after TIMEOUT_CYCLES cycles without mem_RD_valid go to ERR1, HRDATA unchanged; late valid ignored. Undefined: WAIT holds indefinitely.

## Structure
- Shared package ahb3lite_pkg holds HBURST_Type, HTRANS_state, HRESP_state and the read FSM state enum.
- One sub-module: ahb3lite_burst_addr, combinational expected-next-address from prev addr, HSIZE, HBURST.

## Test plan
- NONSEQ read 0x10, mem valid 1 cycle after request returning 0xDEADBEEF -> HREADY low 2 cycles, then HRDATA=0xDEADBEEF, OKAY.
- INCR4 word reads from 0x20 -> mem_RD_addr 0x20,0x24,0x28,0x2C, four OKAY beats, correct data each.
- WRAP4 word read starting 0x38 -> addresses 0x38,0x3C,0x30,0x34; SEQ 0x40 instead of 0x30 -> ERROR pair, no mem_read_flag.
- Read 0x1000 (out of range), halfword at 0x03, HSIZE=3 -> each two-cycle ERROR, HREADY 0 then 1.
- READ_TIMEOUT_EN, mem never valid -> ERROR after 16 WAIT cycles; without macro HREADY stays 0.
- HRESET asserted in WAIT -> HREADY=1, HRESP OKAY, HRDATA=0 immediately; subsequent mem_RD_valid no effect.
